// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: pipeline hazard unit for RIPTIDE-class cores.
// Tracks in-flight register writes with one down-counter per register.
// Tracks conditional branches with a shift register.
// Holds the decoder in reset for a few cycles after a redirect.
// Freezes the back end through a d-cache miss and the replay cycle that follows it.
// Optional feature: define HAZARD_STATS_EN to add the saturating stall counter
// (without it, stall_count is tied to zero).

// Per-register pending-write counter: counts down from WB_LATENCY to 0.
module hazard_pend_ctr #(
  parameter int WB_LATENCY  = 4,
  parameter int FLUSH_STAGE = 4,
  parameter int PEND_W      = 3
) (
  input  logic clk,
  input  logic RST,
  input  logic load,
  input  logic flush,
  input  logic hold,
  output logic busy
);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(WB_LATENCY);
  // Counts above this belong to writes younger than the resolving branch.
  localparam logic [PEND_W-1:0] KILL_THR = PEND_W'(WB_LATENCY - FLUSH_STAGE);

  logic [PEND_W-1:0] cnt;

  // A new write wins, then wrong-path kill, then normal aging (frozen by hold).
  always_ff @(posedge clk) begin
    if (RST)                          cnt <= '0;
    else if (load)                    cnt <= PEND_MAX;
    else if (flush && cnt > KILL_THR) cnt <= '0;
    else if (!hold && cnt != '0)      cnt <= cnt - PEND_W'(1);
  end

  assign busy = (cnt != '0);
endmodule

module hazard_scoreboard #(
  parameter int REG_ADDR_W  = 3,
  parameter int WB_LATENCY  = 4,
  parameter int FLUSH_STAGE = 4,
  parameter int FLUSH_HOLD  = 1,
  parameter int STAT_W      = 16
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  issue_valid,
  input  logic                  issue_wren,
  input  logic [REG_ADDR_W-1:0] issue_reg,
  input  logic                  issue_branch,
  input  logic                  rd_en_a,
  input  logic                  rd_en_b,
  input  logic [REG_ADDR_W-1:0] rd_reg_a,
  input  logic [REG_ADDR_W-1:0] rd_reg_b,
  input  logic                  jmp,
  input  logic                  ret,
  input  logic                  br_resolve,
  input  logic                  back_stall,
  input  logic                  d_cache_miss,
  input  logic                  miss_is_write,
  input  logic                  halt,
  output logic                  hazard,
  output logic                  data_hazard,
  output logic                  branch_hazard,
  output logic                  pipeline_flush,
  output logic                  decoder_RST,
  output logic [STAT_W-1:0]     stall_count
);
  localparam int NUM_REGS = 2 ** REG_ADDR_W;
  localparam int PEND_W   = $clog2(WB_LATENCY + 1);
  localparam int HOLD_W   = (FLUSH_HOLD > 0) ? $clog2(FLUSH_HOLD + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MISS, S_REPLAY} miss_state_t;

  logic [NUM_REGS-1:0]    pend_busy;
  logic [FLUSH_STAGE-1:0] br_sr;
  logic [HOLD_W-1:0]      hold_cnt;
  miss_state_t            state, state_nxt;
  logic                   miss_wr;
  logic                   issue_fire, decoder_flush, reg_hazard, miss_hazard, redirect;

  assign issue_fire = issue_valid & ~hazard & ~back_stall;

  // One pending-write counter per architectural register.
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_pend
    hazard_pend_ctr #(
      .WB_LATENCY (WB_LATENCY),
      .FLUSH_STAGE(FLUSH_STAGE),
      .PEND_W     (PEND_W)
    ) u_pend (
      .clk  (clk),
      .RST  (RST),
      .load (issue_fire & issue_wren & (issue_reg == REG_ADDR_W'(r))),
      .flush(br_resolve),
      .hold (back_stall),
      .busy (pend_busy[r])
    );
  end

  // Same-cycle operand check against outstanding writes.
  always_comb begin
    reg_hazard = (rd_en_a & pend_busy[rd_reg_a]) | (rd_en_b & pend_busy[rd_reg_b]);
  end

  // Conditional branches in flight until they reach FLUSH_STAGE; a resolve wipes them all.
  always_ff @(posedge clk) begin
    if (RST || br_resolve) br_sr <= '0;
    else if (!back_stall) begin
      br_sr[0] <= issue_fire & issue_branch;
      for (int i = 1; i < FLUSH_STAGE; i++) br_sr[i] <= br_sr[i-1];
    end
  end

  // An unconditional redirect must wait for older conditional branches to resolve.
  always_comb begin
    redirect      = jmp | ret;
    branch_hazard = redirect & (|br_sr);
    decoder_flush = (redirect & ~branch_hazard) | br_resolve;
  end

  // Stretch the decoder reset FLUSH_HOLD cycles past the flush itself.
  always_ff @(posedge clk) begin
    if (RST)                  hold_cnt <= '0;
    else if (decoder_flush)   hold_cnt <= HOLD_W'(FLUSH_HOLD);
    else if (hold_cnt != '0)  hold_cnt <= hold_cnt - HOLD_W'(1);
  end

  // Miss FSM state register; reset abandons any miss in progress.
  always_ff @(posedge clk) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Miss FSM next state: one replay cycle after the miss clears.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (d_cache_miss)  state_nxt = S_MISS;
      S_MISS:   if (!d_cache_miss) state_nxt = S_REPLAY;
      S_REPLAY: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Remember whether the miss we entered on was a write miss.
  always_ff @(posedge clk) begin
    if (RST)                                miss_wr <= 1'b0;
    else if (state == S_IDLE && d_cache_miss) miss_wr <= miss_is_write;
  end

  // Miss FSM outputs: write misses also freeze the back end.
  always_comb begin
    miss_hazard = d_cache_miss | (state != S_IDLE);
    data_hazard = (d_cache_miss & miss_is_write) | ((state == S_MISS) & miss_wr);
  end

  // Combined stall and squash outputs.
  always_comb begin
    hazard         = decoder_flush | reg_hazard | branch_hazard | miss_hazard | halt;
    pipeline_flush = br_resolve;
    decoder_RST    = decoder_flush | (hold_cnt != '0) | RST;
  end

`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] stat_q;

  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (RST)                      stat_q <= '0;
    else if (hazard && stat_q != '1) stat_q <= stat_q + STAT_W'(1);
  end

  assign stall_count = stat_q;
`else
  assign stall_count = '0;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard.
// The stimulus process drives a cycle and pushes the expected outputs into a queue.
// Expected outputs come from an age-based reference model.
// A negedge monitor pops the queue and compares against the DUT.
module tb_hazard_scoreboard;
  localparam int AW = 3;
  localparam int NR = 2 ** AW;
  localparam int WB = 4;
  localparam int FS = 4;
  localparam int FH = 1;
  localparam int SW = 16;
  localparam int IDLE_AGE = 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic RST, issue_valid, issue_wren, issue_branch, rd_en_a, rd_en_b;
  logic [AW-1:0] issue_reg, rd_reg_a, rd_reg_b;
  logic jmp, ret, br_resolve, back_stall, d_cache_miss, miss_is_write, halt;
  logic hazard, data_hazard, branch_hazard, pipeline_flush, decoder_RST;
  logic [SW-1:0] stall_count;

  hazard_scoreboard #(.REG_ADDR_W(AW), .WB_LATENCY(WB), .FLUSH_STAGE(FS),
                      .FLUSH_HOLD(FH), .STAT_W(SW)) dut (
    .clk(clk), .RST(RST), .issue_valid(issue_valid), .issue_wren(issue_wren),
    .issue_reg(issue_reg), .issue_branch(issue_branch), .rd_en_a(rd_en_a),
    .rd_en_b(rd_en_b), .rd_reg_a(rd_reg_a), .rd_reg_b(rd_reg_b), .jmp(jmp),
    .ret(ret), .br_resolve(br_resolve), .back_stall(back_stall),
    .d_cache_miss(d_cache_miss), .miss_is_write(miss_is_write), .halt(halt),
    .hazard(hazard), .data_hazard(data_hazard), .branch_hazard(branch_hazard),
    .pipeline_flush(pipeline_flush), .decoder_RST(decoder_RST),
    .stall_count(stall_count));

  typedef struct packed {
    logic rst, iv, wren; logic [AW-1:0] ireg; logic br, ea, eb;
    logic [AW-1:0] ra, rb; logic jmp, ret, bres, bs, dcm, miw, halt;
  } stim_t;

  typedef struct {
    bit hz, dh, bh, pf, drst; int sc; int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   asserts = 0;
  int   fails   = 0;

  // Reference model: age of last write per register (non-stalled cycles since issue),
  // ages of in-flight branches, remaining decoder-reset hold, miss phase, stall tally.
  int age[NR];
  int br_q[$];
  int hold_left, phase, stat, cyc_no;
  bit mwr;

  task automatic model_reset();
    foreach (age[r]) age[r] = IDLE_AGE;
    br_q.delete();
    hold_left = 0; phase = 0; mwr = 1'b0; stat = 0;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  task automatic chk(input string name, input int act, input int expv, input int c);
    asserts++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, c, act, expv);
    end
  endtask

  // Drive one cycle, predict its outputs, then advance the model across the next edge.
  task automatic cyc(input stim_t s);
    exp_t e;
    bit   redir, rh, bh, df, mh, hz, fire;
    int   nq[$];
    @(posedge clk); #1;
    RST = s.rst; issue_valid = s.iv; issue_wren = s.wren; issue_reg = s.ireg;
    issue_branch = s.br; rd_en_a = s.ea; rd_en_b = s.eb; rd_reg_a = s.ra; rd_reg_b = s.rb;
    jmp = s.jmp; ret = s.ret; br_resolve = s.bres; back_stall = s.bs;
    d_cache_miss = s.dcm; miss_is_write = s.miw; halt = s.halt;

    redir = s.jmp || s.ret;
    rh    = (s.ea && age[s.ra] < WB) || (s.eb && age[s.rb] < WB);
    bh    = redir && (br_q.size() > 0);
    df    = (redir && !bh) || s.bres;
    mh    = s.dcm || (phase != 0);
    hz    = df || rh || bh || mh || s.halt;
    fire  = s.iv && !hz && !s.bs;

    e.hz = hz; e.bh = bh; e.pf = s.bres;
    e.dh = (s.dcm && s.miw) || (phase == 1 && mwr);
    e.drst = df || (hold_left > 0) || s.rst;
`ifdef HAZARD_STATS_EN
    e.sc = stat;
`else
    e.sc = 0;
`endif
    e.cyc = cyc_no;
    exp_q.push_back(e);
    cyc_no++;

    if (s.rst) model_reset();
    else begin
      if (hz && stat < (2 ** SW) - 1) stat++;
      foreach (age[r]) begin
        if (fire && s.wren && int'(s.ireg) == r) age[r] = 0;
        else if (s.bres && age[r] < FS)         age[r] = IDLE_AGE;
        else if (!s.bs && age[r] < IDLE_AGE)     age[r]++;
      end
      if (s.bres) br_q.delete();
      else if (!s.bs) begin
        foreach (br_q[i]) br_q[i]++;
        if (fire && s.br) br_q.push_back(0);
        foreach (br_q[i]) if (br_q[i] < FS) nq.push_back(br_q[i]);
        br_q = nq;
      end
      if (df) hold_left = FH;
      else if (hold_left > 0) hold_left--;
      case (phase)
        0: if (s.dcm) begin phase = 1; mwr = s.miw; end
        1: if (!s.dcm) phase = 2;
        default: phase = 0;
      endcase
    end
  endtask

  // Monitor: every presented cycle is checked against the oldest prediction.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("hazard",         int'(hazard),         int'(e.hz),   e.cyc);
      chk("data_hazard",    int'(data_hazard),    int'(e.dh),   e.cyc);
      chk("branch_hazard",  int'(branch_hazard),  int'(e.bh),   e.cyc);
      chk("pipeline_flush", int'(pipeline_flush), int'(e.pf),   e.cyc);
      chk("decoder_RST",    int'(decoder_RST),    int'(e.drst), e.cyc);
      chk("stall_count",    int'(stall_count),    e.sc,         e.cyc);
    end
  end

  initial begin
    stim_t s;
    int miss_left;
    bit miss_w;
    model_reset();
    cyc_no = 0; miss_left = 0; miss_w = 1'b0;
    s = idle(); s.rst = 1'b1;
    RST = 1'b1; issue_valid = 0; issue_wren = 0; issue_reg = '0; issue_branch = 0;
    rd_en_a = 0; rd_en_b = 0; rd_reg_a = '0; rd_reg_b = '0; jmp = 0; ret = 0;
    br_resolve = 0; back_stall = 0; d_cache_miss = 0; miss_is_write = 0; halt = 0;

    // Reset then release.
    cyc(s); cyc(s);
    repeat (2) cyc(idle());

    // Read-after-write on r3, unrelated r2, and r3 with a back-end freeze.
    for (int sc = 0; sc < 3; sc++) begin
      for (int k = 0; k < 9; k++) begin
        s = idle(); s.ea = 1'b1; s.ra = (sc == 1) ? 3'd2 : 3'd3;
        if (k == 0) begin s.iv = 1'b1; s.wren = 1'b1; s.ireg = 3'd3; end
        if (sc == 2 && (k == 2 || k == 3)) s.bs = 1'b1;
        cyc(s);
      end
      repeat (2) cyc(idle());
    end

    // Jump behind a conditional branch, then after it has left the window.
    for (int k = 0; k < 9; k++) begin
      s = idle();
      if (k == 0) begin s.iv = 1'b1; s.br = 1'b1; end
      if (k == 1 || k == 5) s.jmp = 1'b1;
      cyc(s);
    end

    // Taken branch kills a younger write.
    for (int k = 0; k < 8; k++) begin
      s = idle();
      if (k == 0) begin s.iv = 1'b1; s.br = 1'b1; end
      if (k == 1) begin s.iv = 1'b1; s.wren = 1'b1; s.ireg = 3'd2; end
      if (k == 4) s.bres = 1'b1;
      if (k == 5) begin s.ea = 1'b1; s.ra = 3'd2; end
      cyc(s);
    end

    // Ten-cycle write miss followed by replay.
    for (int k = 0; k < 15; k++) begin
      s = idle();
      if (k < 10) begin s.dcm = 1'b1; s.miw = 1'b1; end
      cyc(s);
    end

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      s = idle();
      s.rst  = ($urandom_range(0, 199) == 0);
      s.iv   = $urandom_range(0, 1);
      s.wren = ($urandom_range(0, 9) < 7);
      s.ireg = AW'($urandom);
      s.br   = ($urandom_range(0, 99) < 15);
      s.ea   = $urandom_range(0, 1);
      s.eb   = $urandom_range(0, 1);
      s.ra   = AW'($urandom);
      s.rb   = AW'($urandom);
      s.jmp  = ($urandom_range(0, 99) < 5);
      s.ret  = ($urandom_range(0, 99) < 5);
      s.bres = ($urandom_range(0, 99) < 4);
      s.bs   = ($urandom_range(0, 99) < 10);
      s.halt = ($urandom_range(0, 99) < 3);
      if (miss_left == 0 && $urandom_range(0, 49) == 0) begin
        miss_left = $urandom_range(1, 8);
        miss_w    = $urandom_range(0, 1);
      end
      if (miss_left > 0) begin
        s.dcm = 1'b1; s.miw = miss_w; miss_left--;
      end else s.miw = $urandom_range(0, 1);
      cyc(s);
    end

    repeat (3) cyc(idle());
    repeat (3) @(posedge clk);
    chk("queue_drain", exp_q.size(), 0, cyc_no);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
